// File: rtl/ds1302_time_sequencer.sv
// rtl/ds1302_time_sequencer.sv - DS1302 command sequencer: periodic time read and time set.
// Drives one-byte transactions over the serial driver's valid/busy handshake.
module ds1302_time_sequencer #(
    parameter int POLL_CYCLES  = 100_000_000,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       i_set,
    input  logic [7:0] i_set_sec,
    input  logic [7:0] i_set_min,
    input  logic [7:0] i_set_hour,
    input  logic       i_busy,
    input  logic [7:0] i_receive,
    output logic [4:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_RW,
    output logic       o_valid,
    output logic [7:0] o_sec,
    output logic [7:0] o_min,
    output logic [7:0] o_hour,
    output logic       o_time_valid,
    output logic       o_set_done,
    output logic       o_error
);

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic            mode_set_q, mode_set_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [PW-1:0]   poll_cnt_q;
    logic            poll_pend_q, poll_pend_d;
    logic            set_pend_q, set_pend_d;
    logic [7:0]      set_sec_q, set_min_q, set_hour_q;
    logic [7:0]      sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [4:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            rw_q, rw_d;
    logic            valid_q, valid_d;
    logic [7:0]      sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic            tv_q, tv_d, sd_q, sd_d, err_q, err_d;

    logic            poll_wrap;
    logic [1:0]      last_k;
    logic [4:0]      tr_addr;
    logic [7:0]      tr_data;

    assign poll_wrap = (poll_cnt_q == PW'(POLL_CYCLES - 1));
    assign last_k    = mode_set_q ? 2'd3 : 2'd2;

    // Sequence table: SET starts by clearing write-protect in the control register.
    always_comb begin
        tr_addr = {3'b000, k_q};
        tr_data = 8'h00;
        if (mode_set_q) begin
            case (k_q)
                2'd0:    begin tr_addr = 5'd7; tr_data = 8'h00;      end
                2'd1:    begin tr_addr = 5'd0; tr_data = set_sec_q;  end
                2'd2:    begin tr_addr = 5'd1; tr_data = set_min_q;  end
                default: begin tr_addr = 5'd2; tr_data = set_hour_q; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            poll_cnt_q <= '0;
            set_sec_q  <= 8'h00;
            set_min_q  <= 8'h00;
            set_hour_q <= 8'h00;
        end else begin
            poll_cnt_q <= poll_wrap ? '0 : poll_cnt_q + PW'(1);
            if (i_set) begin
                set_sec_q  <= i_set_sec & 8'h7F;
                set_min_q  <= i_set_min;
                set_hour_q <= i_set_hour & 8'h7F;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            mode_set_q  <= 1'b0;
            tmo_q       <= '0;
            poll_pend_q <= 1'b0;
            set_pend_q  <= 1'b0;
            sh0_q       <= 8'h00;
            sh1_q       <= 8'h00;
            sh2_q       <= 8'h00;
            addr_q      <= 5'd0;
            data_q      <= 8'h00;
            rw_q        <= 1'b0;
            valid_q     <= 1'b0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            tv_q        <= 1'b0;
            sd_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mode_set_q  <= mode_set_d;
            tmo_q       <= tmo_d;
            poll_pend_q <= poll_pend_d;
            set_pend_q  <= set_pend_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            valid_q     <= valid_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            tv_q        <= tv_d;
            sd_q        <= sd_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mode_set_d  = mode_set_q;
        tmo_d       = tmo_q;
        poll_pend_d = poll_pend_q;
        set_pend_d  = set_pend_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_d        = rw_q;
        valid_d     = 1'b0;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        tv_d        = 1'b0;
        sd_d        = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (set_pend_q) begin
                    set_pend_d = 1'b0;
                    mode_set_d = 1'b1;
                    k_d        = 2'd0;
                    state_d    = ISSUE;
                end else if (poll_pend_q) begin
                    poll_pend_d = 1'b0;
                    mode_set_d  = 1'b0;
                    k_d         = 2'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_busy) begin
                    addr_d  = tr_addr;
                    data_d  = tr_data;
                    rw_d    = !mode_set_q;
                    valid_d = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!i_busy) begin
                    if (!mode_set_q) begin
                        case (k_q)
                            2'd0:    sh0_d = i_receive;
                            2'd1:    sh1_d = i_receive;
                            default: sh2_d = i_receive;
                        endcase
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (k_q == last_k) begin
                    if (mode_set_q) begin
                        sd_d = 1'b1;
                    end else begin
                        sec_d  = sh0_q & 8'h7F;
                        min_d  = sh1_q & 8'h7F;
                        hour_d = sh2_q & 8'h3F;
                        tv_d   = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving mid-sequence are remembered and serviced from IDLE.
        if (i_set)     set_pend_d  = 1'b1;
        if (poll_wrap) poll_pend_d = 1'b1;
    end

    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_RW         = rw_q;
    assign o_valid      = valid_q;
    assign o_sec        = sec_q;
    assign o_min        = min_q;
    assign o_hour       = hour_q;
    assign o_time_valid = tv_q;
    assign o_set_done   = sd_q;
    assign o_error      = err_q;

endmodule

// File: tb/tb_ds1302_time_sequencer.sv
// tb/tb_ds1302_time_sequencer.sv - directed self-checking bench for ds1302_time_sequencer.
module tb_ds1302_time_sequencer;

    localparam int POLL = 64;
    localparam int BTO  = 255;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       i_set = 1'b0;
    logic [7:0] i_set_sec = 8'h00, i_set_min = 8'h00, i_set_hour = 8'h00;
    logic       drv_busy = 1'b0, hold_busy = 1'b0;
    logic       i_busy;
    logic [7:0] i_receive = 8'h00;
    logic [4:0] o_addr;
    logic [7:0] o_data, o_sec, o_min, o_hour;
    logic       o_RW, o_valid, o_time_valid, o_set_done, o_error;

    assign i_busy = drv_busy | hold_busy;

    ds1302_time_sequencer #(.POLL_CYCLES(POLL), .BUSY_TIMEOUT(BTO)) dut (
        .clk(clk), .reset_p(reset_p), .i_set(i_set), .i_set_sec(i_set_sec),
        .i_set_min(i_set_min), .i_set_hour(i_set_hour), .i_busy(i_busy),
        .i_receive(i_receive), .o_addr(o_addr), .o_data(o_data), .o_RW(o_RW),
        .o_valid(o_valid), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_time_valid(o_time_valid), .o_set_done(o_set_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int tv_cnt = 0, sd_cnt = 0, err_cnt = 0, v_cnt = 0, v_wide = 0;
    int cyc = 0, last_v_cyc = 0, tv_at_wp = 0;
    int drv_mode = 0;
    logic prev_v = 1'b0;
    logic [4:0] log_a[$];
    logic [7:0] log_d[$];
    logic       log_rw[$];

    function automatic logic [7:0] rom_of(input logic [4:0] a);
        case (a)
            5'd0:    return 8'h45;
            5'd1:    return 8'h30;
            5'd2:    return 8'h92;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (o_time_valid) tv_cnt++;
        if (o_set_done) sd_cnt++;
        if (o_error) err_cnt++;
        if (o_valid) begin
            v_cnt++;
            last_v_cyc = cyc;
            log_a.push_back(o_addr);
            log_d.push_back(o_data);
            log_rw.push_back(o_RW);
            if (o_addr == 5'd7 && !o_RW) tv_at_wp = tv_cnt;
        end
        if (o_valid && prev_v) v_wide++;
        prev_v = o_valid;
    end

    // Driver model: busy for 10 cycles per accepted request, read data presented throughout.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_valid && drv_mode == 0 && !reset_p) begin
                i_receive = rom_of(o_addr);
                drv_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                drv_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int sel(input int w);
        case (w)
            0:       return tv_cnt;
            1:       return sd_cnt;
            2:       return err_cnt;
            default: return v_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input int w, input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            step();
            if (sel(w) >= target) return;
        end
        check(tag, sel(w), target);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 500; i++) begin
            step();
            if (int'(dut.state_q) == 0) return;
        end
        check(tag, int'(dut.state_q), 0);
    endtask

    initial begin
        logic [4:0] ea[4];
        logic [7:0] ed[4];
        int tv0, e0, v0;
        bit found;

        // 1: reset state, then first periodic read
        repeat (3) step();
        check("rst_addr", o_addr, 0);
        check("rst_data", o_data, 0);
        check("rst_ctl", {o_RW, o_valid, o_time_valid, o_set_done, o_error}, 0);
        check("rst_time", {o_sec, o_min, o_hour}, 0);
        reset_p = 1'b0;
        wait_cnt(0, 1, 600, "t1_wait_tv");
        check("t1_tv_pulse", o_time_valid, 1);
        check("t1_sec", o_sec, 8'h45);
        check("t1_min", o_min, 8'h30);
        check("t1_hour", o_hour, 8'h12);
        check("t1_nlog", log_a.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", log_a[i], i);
            check("t1_rw", log_rw[i], 1);
        end
        step();
        check("t1_tv_1cyc", o_time_valid, 0);
        check("t1_tv_cnt", tv_cnt, 1);

        // 2: set sequence with masked seconds bit7
        wait_idle("t2_idle");
        log_a.delete(); log_d.delete(); log_rw.delete();
        i_set_sec = 8'hD9; i_set_min = 8'h59; i_set_hour = 8'h23; i_set = 1'b1;
        step();
        i_set = 1'b0;
        wait_cnt(1, 1, 600, "t2_wait_sd");
        check("t2_sd_pulse", o_set_done, 1);
        check("t2_no_tv", tv_cnt, tv_at_wp);
        ea = '{5'd7, 5'd0, 5'd1, 5'd2};
        ed = '{8'h00, 8'h59, 8'h59, 8'h23};
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", log_a[i], ea[i]);
            check("t2_data", log_d[i], ed[i]);
            check("t2_rw", log_rw[i], 0);
        end
        check("t2_sec_kept", o_sec, 8'h45);

        // 3: i_set and poll wrap in the same cycle, FSM idle
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (int'(dut.state_q) == 0 && int'(dut.poll_cnt_q) == POLL - 1) found = 1'b1;
        end
        check("t3_align", found, 1);
        log_a.delete(); log_d.delete(); log_rw.delete();
        tv0 = tv_cnt;
        i_set_sec = 8'h12; i_set_min = 8'h34; i_set_hour = 8'h85; i_set = 1'b1;
        step();
        i_set = 1'b0;
        wait_cnt(1, 2, 600, "t3_wait_sd");
        wait_cnt(0, tv0 + 1, 600, "t3_wait_tv");
        ed = '{8'h00, 8'h12, 8'h34, 8'h05};
        for (int i = 0; i < 4; i++) begin
            check("t3_waddr", log_a[i], ea[i]);
            check("t3_wdata", log_d[i], ed[i]);
            check("t3_wrw", log_rw[i], 0);
        end
        for (int i = 0; i < 3; i++) begin
            check("t3_raddr", log_a[4 + i], i);
            check("t3_rrw", log_rw[4 + i], 1);
        end

        // 4: busy never rises -> timeout
        wait_idle("t4_idle");
        drv_mode = 1;
        tv0 = tv_cnt;
        e0 = err_cnt;
        wait_cnt(2, e0 + 1, 800, "t4_wait_err");
        check("t4_err_pulse", o_error, 1);
        check("t4_state_idle", int'(dut.state_q), 0);
        check("t4_sec_kept", o_sec, 8'h45);
        check("t4_no_tv", tv_cnt, tv0);
        check("t4_latency", cyc - last_v_cyc, BTO);
        drv_mode = 0;
        step();
        check("t4_err_1cyc", o_error, 0);

        // 5: reset during the second read
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (o_valid && o_addr == 5'd1 && o_RW) found = 1'b1;
        end
        check("t5_find_rd2", found, 1);
        repeat (3) step();
        reset_p = 1'b1;
        step();
        check("t5_valid", o_valid, 0);
        check("t5_addr", o_addr, 0);
        check("t5_time", {o_sec, o_min, o_hour}, 0);
        check("t5_pulses", {o_time_valid, o_set_done, o_error}, 0);
        reset_p = 1'b0;
        log_a.delete(); log_d.delete(); log_rw.delete();
        tv0 = tv_cnt;
        wait_cnt(0, tv0 + 1, 400, "t5_wait_tv");
        check("t5_nlog", log_a.size(), 3);
        for (int i = 0; i < 3; i++) check("t5_addr_seq", log_a[i], i);
        check("t5_sec", o_sec, 8'h45);
        check("t5_hour", o_hour, 8'h12);

        // 6: busy held high while ISSUE is waiting
        wait_idle("t6_idle");
        hold_busy = 1'b1;
        v0 = v_cnt;
        repeat (100) step();
        check("t6_withheld", v_cnt, v0);
        check("t6_in_issue", int'(dut.state_q), 1);
        hold_busy = 1'b0;
        wait_cnt(3, v0 + 1, 10, "t6_wait_valid");
        check("t6_addr", o_addr, 0);
        check("t6_rw", o_RW, 1);
        tv0 = tv_cnt;
        wait_cnt(0, tv0 + 1, 400, "t6_wait_tv");
        check("t6_sec", o_sec, 8'h45);
        check("valid_width", v_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
